// File: rtl/sort_window_loader.sv
`default_nettype none
// ============================================================================
// Module      : sort_window_loader
// Description : Packs a valid/ready sample stream into NUM_VALS-sample windows
//               for the byte sorter. Define SORT_WINDOW_SLIDING_EN for
//               sliding (one window per sample) instead of tumbling windows.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_window_loader #(
    parameter int NUM_VALS = 9,
    parameter int SIZE     = 8,
    parameter int CNT_W    = $clog2(NUM_VALS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [SIZE-1:0]          in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_VALS*SIZE-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         fill_level
);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_HOLD   = 2'd1,
        S_PRIMED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_VALS - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_fill;
    logic [CNT_W-1:0]           w_fill_nxt;
    logic [NUM_VALS*SIZE-1:0]   r_window;
    logic                       w_accept;
    logic                       w_handshake;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_FILL, S_PRIMED: in_ready = 1'b1;
            S_HOLD: begin
                out_valid = 1'b1;
`ifdef SORT_WINDOW_SLIDING_EN
                in_ready  = out_ready;
`endif
            end
            default: ;
        endcase
    end

    // flush wins over both sides of the interface in the same cycle
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_handshake = out_valid && out_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        if (flush) begin
            w_state_nxt = S_FILL;
            w_fill_nxt  = '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        w_fill_nxt = r_fill + C_ONE;
                        if (r_fill == C_LAST) begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_handshake) begin
`ifdef SORT_WINDOW_SLIDING_EN
                        if (!w_accept) begin
                            w_state_nxt = S_PRIMED;
                        end
`else
                        w_state_nxt = S_FILL;
                        w_fill_nxt  = '0;
`endif
                    end
                end
                S_PRIMED: begin
                    if (w_accept) begin
                        w_state_nxt = S_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FILL;
            r_fill   <= '0;
            r_window <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            // oldest sample falls out of slot 0, newest enters the top slot
            if (w_accept) begin
                r_window <= {in_data, r_window[NUM_VALS*SIZE-1:SIZE]};
            end
        end
    end

    assign out_data   = r_window;
    assign fill_level = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_sort_window_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_window_loader
// Description : Table-driven self-checking bench for sort_window_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_window_loader;

    localparam int NV = 9;
    localparam int SZ = 8;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [71:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fill_level;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [3:0]  e_fill;
        logic        chk;
        logic [71:0] e_data;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] gs[9];

    sort_window_loader #(.NUM_VALS(NV), .SIZE(SZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] win_seq(input logic [7:0] first);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = first + 8'(k);
        return w;
    endfunction

    function automatic void add(input logic r, input logic f, input logic iv,
                                input logic [7:0] d, input logic ordy,
                                input logic eir, input logic eov,
                                input logic [3:0] efill, input logic ck,
                                input logic [71:0] ed);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = eir; v.e_ov = eov; v.e_fill = efill; v.chk = ck; v.e_data = ed;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; flush = v.flush; in_valid = v.iv; in_data = v.d; out_ready = v.ordy;
        @(posedge clk);
        #1;
        check("in_ready", idx, 72'(in_ready), 72'(v.e_ir));
        check("out_valid", idx, 72'(out_valid), 72'(v.e_ov));
        check("fill_level", idx, 72'(fill_level), 72'(v.e_fill));
        if (v.chk) check("out_data", idx, out_data, v.e_data);
    endtask

    initial begin
        logic [71:0] w2;
        int          t0;
        int          t1;
        int          hi_cnt;
        logic [71:0] d0;
        logic [71:0] d1;

        checks = 0; errors = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        gs = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'h7F, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        for (int k = 0; k < 9; k++) w2[k*8 +: 8] = gs[k];

        //        rst f  iv d      rdy  ir ov fill chk data
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 1, '0);
`ifndef SORT_WINDOW_SLIDING_EN
        for (int i = 0; i < 9; i++)
            add(0, 0, 1, 8'h10 + 8'(i), 0, i != 8, i == 8, 4'(i + 1), i == 8, win_seq(8'h10));
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 8'h55, 0, 0, 1, 9, 1, win_seq(8'h10));
        add(0, 0, 1, 8'h99, 1, 1, 0, 0, 0, '0);
        add(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 9; i++) begin
            add(0, 0, 0, 8'h00, 0, 1, 0, 4'(i), 0, '0);
            add(0, 0, 0, 8'h00, 0, 1, 0, 4'(i), 0, '0);
            add(0, 0, 1, gs[i], 0, i != 8, i == 8, 4'(i + 1), i == 8, w2);
        end
        add(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 8'h20 + 8'(i), 0, 1, 0, 4'(i + 1), 0, '0);
        add(0, 1, 1, 8'hAA, 0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 9; i++)
            add(0, 0, 1, 8'h30 + 8'(i), 0, i != 8, i == 8, 4'(i + 1), i == 8, win_seq(8'h30));
        add(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, '0);
        add(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, '0);
        // out_ready held high while filling must be ignored
        for (int i = 0; i < 9; i++)
            add(0, 0, 1, 8'h40 + 8'(i), 1, i != 8, i == 8, 4'(i + 1), i == 8, win_seq(8'h40));
        add(1, 0, 1, 8'h77, 1, 1, 0, 0, 1, '0);
        add(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, '0);
`else
        for (int i = 0; i < 9; i++)
            add(0, 0, 1, 8'(i + 1), 0, i != 8, i == 8, 4'(i + 1), i == 8, win_seq(8'd1));
        add(0, 0, 1, 8'd10, 1, 1, 1, 9, 1, win_seq(8'd2));
        add(0, 0, 1, 8'd11, 1, 1, 1, 9, 1, win_seq(8'd3));
        add(0, 0, 0, 8'd0,  1, 1, 0, 9, 0, '0);
        add(0, 0, 0, 8'd0,  0, 1, 0, 9, 0, '0);
        add(0, 0, 1, 8'd12, 0, 0, 1, 9, 1, win_seq(8'd4));
        add(0, 1, 1, 8'd13, 1, 1, 0, 0, 0, '0);
        add(0, 0, 1, 8'd14, 0, 1, 0, 1, 0, '0);
        add(1, 0, 0, 8'd0,  0, 1, 0, 0, 1, '0);
`endif

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Free-running source with consumer always ready; in_data = cycle index
        t0 = -1; t1 = -1; hi_cnt = 0; d0 = '0; d1 = '0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            in_data = 8'(n);
            @(posedge clk);
            #1;
            if (out_valid) begin
                hi_cnt++;
                if (t0 < 0) begin
                    t0 = n; d0 = out_data;
                end else if (t1 < 0 && n != t0 + 1) begin
                    t1 = n; d1 = out_data;
                end
                if (n == 19) d1 = out_data;
            end
        end
`ifndef SORT_WINDOW_SLIDING_EN
        check("first_window_cycle", 0, 72'(t0), 72'(8));
        check("second_window_cycle", 0, 72'(t1), 72'(18));
        check("first_window_data", 0, d0, win_seq(8'd0));
        check("second_window_data", 0, d1, win_seq(8'd10));
        check("valid_cycles", 0, 72'(hi_cnt), 72'(4));
`else
        check("first_window_cycle", 0, 72'(t0), 72'(8));
        check("first_window_data", 0, d0, win_seq(8'd0));
        check("valid_cycles", 0, 72'(hi_cnt), 72'(32));
        check("window_at_19", 0, d1, win_seq(8'd11));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
